crc8_serial: RTL and testbench
==============================

// Module: crc8_serial
// PURPOSE
//   Serial CRC generator/checker for the UART frame receiver: folds one received bit per
//   enabled clock (MSB-first) into an 8-bit CRC register; the receiver compares crc_out
//   bit-by-bit (bit 7 first) against the transmitted CRC field after the frame data.
//   Default algorithm is CRC-8/SMBUS: poly 0x07, init 0x00, no reflection, no final XOR.
// PARAMETERS
//   WIDTH  8      CRC register width (>=2)
//   POLY   8'h07  generator polynomial, implicit x^WIDTH term omitted
//   INIT   8'h00  value loaded on reset and on clr
// PORTS
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   clr      in   1      synchronous clear to INIT (start of each frame)
//   enable   in   1      consume din this cycle
//   din      in   1      serial data bit, MSB of each byte first
//   crc_out  out  WIDTH  current CRC register value (registered)
// BEHAVIOUR
//   - reset_n=0: crc_out <= INIT immediately, independent of clk; all other inputs ignored.
//   - Per rising edge, priority: clr > enable > hold.
//     clr=1: crc <= INIT (enable/din ignored that cycle).
//     enable=1: fb = crc[WIDTH-1] ^ din; crc <= {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
//     else: crc holds.
//   - Latency: one cycle; crc_out reflects all bits accepted up to the previous edge.
//   - No handshake; enable may be held high any number of cycles (back-to-back bits).
//   - Residue: after a message plus its own CRC (MSB first), crc_out == 0.
//   - Pure XOR/shift arithmetic, no overflow; width fixed at WIDTH.
//   - Reset deasserting mid-message: register restarts from INIT; caller must restart frame.
// CONFIGURATION
//   CRC_BYTE_EN defined: extra ports byte_en (in,1) and din_byte (in,8). byte_en=1 folds
//     din_byte in one cycle, exactly equal to 8 serial steps din_byte[7]..din_byte[0].
//     Priority clr > byte_en > enable (serial bit dropped when byte_en=1).
//   CRC_BYTE_EN undefined: ports absent, serial path only; behaviour otherwise identical.
// STRUCTURE
//   - Package crc_pkg: CRC_WIDTH, CRC8_POLY=8'h07, CRC8_INIT=8'h00, typedef logic [7:0] crc8_t,
//     function crc_step(crc, bit) used by serial path and unrolled 8x for byte path.
//   - No sub-module; byte path is the unrolled function inside this module.
// TESTING
//   - Reset: reset_n=0 asynchronously mid-cycle -> crc_out=0x00 before next clk edge.
//   - Byte 0x01 serially (0,0,0,0,0,0,0,1) from INIT -> crc_out=0x07; byte 0x80 -> 0x89.
//   - ASCII "123456789" serially, 72 enabled bits -> crc_out=0xF4; then bits of 0xF4 -> 0x00.
//   - Gapped enable: same 0x80 with enable low between every bit -> still 0x89; holds while low.
//   - clr and enable high same cycle with crc=0x89 -> crc_out=0x00, din ignored.
//   - CRC_BYTE_EN: byte_en with 0x31..0x39 on 9 consecutive cycles -> 0xF4, matches serial run.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: CRC-8/SMBUS constants and the single-bit MSB-first CRC step shared by the serial and byte paths
package crc_pkg;
  localparam int CRC_WIDTH = 8;
  typedef logic [CRC_WIDTH-1:0] crc8_t;
  localparam crc8_t CRC8_POLY = 8'h07;
  localparam crc8_t CRC8_INIT = 8'h00;
  // Carried at 32 bits so any register width up to 32 can share it; w masks the live bits
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b, input logic [31:0] poly, input int w);
    logic fb;
    fb = crc[w-1] ^ b;
    return ((crc << 1) ^ (fb ? poly : 32'd0)) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: serial MSB-first CRC generator/checker, one bit per enabled clock.
// Defining CRC_BYTE_EN adds byte_en/din_byte to fold a whole byte in one cycle.
module crc8_serial
  import crc_pkg::*;
#(
  parameter int WIDTH = CRC_WIDTH,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(CRC8_POLY),
  parameter logic [WIDTH-1:0] INIT = WIDTH'(CRC8_INIT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             enable,
  input  logic             din,
`ifdef CRC_BYTE_EN
  input  logic             byte_en,
  input  logic [7:0]       din_byte,
`endif
  output logic [WIDTH-1:0] crc_out
);
  logic [WIDTH-1:0] ser, nxt;
  assign ser = WIDTH'(crc_step(32'(crc_out), din, 32'(POLY), WIDTH));
`ifdef CRC_BYTE_EN
  logic [WIDTH-1:0] byt;
  always_comb begin
    byt = crc_out;
    for (int k = 0; k < 8; k++) byt = WIDTH'(crc_step(32'(byt), din_byte[7-k], 32'(POLY), WIDTH));
  end
  assign nxt = byte_en ? byt : enable ? ser : crc_out;
`else
  assign nxt = enable ? ser : crc_out;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) crc_out <= INIT;
    else crc_out <= clr ? INIT : nxt;
endmodule

// File: tb/tb_crc8_serial.sv
// tb_crc8_serial: directed table-driven checks of crc8_serial (CRC-8/SMBUS), byte path under CRC_BYTE_EN
module tb_crc8_serial;
  logic clk = 1'b0, reset_n = 1'b0, clr = 1'b0, enable = 1'b0, din = 1'b0;
  logic [7:0] crc_out;
  int checks = 0, errors = 0;
`ifdef CRC_BYTE_EN
  logic byte_en = 1'b0;
  logic [7:0] din_byte = 8'h00;
`endif

  crc8_serial dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .enable(enable), .din(din),
`ifdef CRC_BYTE_EN
    .byte_en(byte_en), .din_byte(din_byte),
`endif
    .crc_out(crc_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic [7:0] exp; } vec_t;
  vec_t vecs[6];
  logic [7:0] msg[9];
  logic [7:0] steps80[8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic clear();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) enable = 1'b1;
      din = b[i];
    end
    @(negedge clk) enable = 1'b0;
  endtask

  initial begin
    vecs = '{'{8'h01, 8'h07}, '{8'h80, 8'h89}, '{8'h31, 8'h97},
             '{8'hFF, 8'hF3}, '{8'h00, 8'h00}, '{8'h02, 8'h0E}};
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    steps80 = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC7, 8'h89};
    repeat (2) @(negedge clk);
    check("reset_value", crc_out, 8'h00);
    reset_n = 1'b1;
    // single bytes from INIT, then their own CRC drives the residue to zero
    for (int v = 0; v < 6; v++) begin
      clear();
      send_byte(vecs[v].data);
      check($sformatf("byte_%02h", vecs[v].data), crc_out, vecs[v].exp);
      send_byte(vecs[v].exp);
      check($sformatf("residue_%02h", vecs[v].data), crc_out, 8'h00);
    end
    // 72 back-to-back enabled bits
    clear();
    for (int j = 0; j < 9; j++)
      for (int i = 7; i >= 0; i--) begin
        @(negedge clk) enable = 1'b1;
        din = msg[j][i];
      end
    @(negedge clk) enable = 1'b0;
    check("check_123456789", crc_out, 8'hF4);
    send_byte(8'hF4);
    check("residue_123456789", crc_out, 8'h00);
    // gapped enable: register must hold across the idle cycles
    clear();
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) enable = 1'b1;
      din = (i == 7);
      @(negedge clk) enable = 1'b0;
      din = 1'b1;
      @(negedge clk);
      check($sformatf("gap_hold_%0d", 7 - i), crc_out, steps80[7-i]);
    end
    check("gap_final", crc_out, 8'h89);
    // clr beats enable; din=1 would otherwise give 0x12
    @(negedge clk) clr = 1'b1;
    enable = 1'b1;
    din = 1'b1;
    @(negedge clk) clr = 1'b0;
    enable = 1'b0;
    check("clr_priority", crc_out, 8'h00);
    // asynchronous reset mid-cycle, observed before the next edge
    send_byte(8'h80);
    check("pre_async_reset", crc_out, 8'h89);
    #2 reset_n = 1'b0;
    #1 check("async_reset", crc_out, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    check("reset_hold", crc_out, 8'h00);
`ifdef CRC_BYTE_EN
    clear();
    for (int j = 0; j < 9; j++) begin
      @(negedge clk) byte_en = 1'b1;
      din_byte = msg[j];
    end
    @(negedge clk) byte_en = 1'b0;
    check("byte_path_123456789", crc_out, 8'hF4);
    // byte_en beats a concurrent serial bit
    clear();
    @(negedge clk) byte_en = 1'b1;
    din_byte = 8'h80;
    enable = 1'b1;
    din = 1'b1;
    @(negedge clk) byte_en = 1'b0;
    enable = 1'b0;
    check("byte_over_serial", crc_out, 8'h89);
    @(negedge clk) clr = 1'b1;
    byte_en = 1'b1;
    din_byte = 8'h31;
    @(negedge clk) clr = 1'b0;
    byte_en = 1'b0;
    check("clr_over_byte", crc_out, 8'h00);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
